// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with ready/valid on both sides, occupancy count,
// almost-full/almost-empty flags, selectable FWFT/registered read, flush and sticky error flags.
module sync_fifo_param #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 16,
  parameter int FWFT          = 1,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       FLUSH,
  output logic                       WR_RDY,
  input  logic                       WR_EN,
  input  logic [WIDTH-1:0]           WR_DATA,
  output logic                       RD_VALID,
  input  logic                       RD_EN,
  output logic [WIDTH-1:0]           RD_DATA,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       ALMOST_FULL,
  output logic                       ALMOST_EMPTY,
  output logic                       OVERFLOW,
  output logic                       UNDERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    count;
  logic             ovf;
  logic             unf;
  logic             wr_acc;
  logic             rd_acc;
  logic             wr_refused;
  logic             rd_refused;

  // Handshake decode uses registered occupancy only, never the same-cycle enables.
  assign WR_RDY   = (count != PW'(DEPTH));
  assign RD_VALID = (count != '0);

  // Flush outranks both sides: nothing is accepted and no error is recorded.
  assign wr_acc     = WR_EN & WR_RDY & ~FLUSH;
  assign rd_acc     = RD_EN & RD_VALID & ~FLUSH;
  assign wr_refused = WR_EN & ~WR_RDY & ~FLUSH;
  assign rd_refused = RD_EN & ~RD_VALID & ~FLUSH;

  assign COUNT        = count;
  assign ALMOST_FULL  = (count >= PW'(AFULL_THRESH));
  assign ALMOST_EMPTY = (count <= PW'(AEMPTY_THRESH));
  assign OVERFLOW     = ovf;
  assign UNDERFLOW    = unf;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
      if (wr_refused) ovf <= 1'b1;
      if (rd_refused) unf <= 1'b1;
    end
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= WR_DATA;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign RD_DATA = mem[rd_ptr[AW-1:0]];
    end else begin : g_reg
      logic [WIDTH-1:0] rd_data_p1;

      // Read stage: head word captured on acceptance, held otherwise (flush leaves it alone).
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)      rd_data_p1 <= '0;
        else if (rd_acc) rd_data_p1 <= mem[rd_ptr[AW-1:0]];
      end

      assign RD_DATA = rd_data_p1;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one FWFT instance and one registered-read instance, 8x4.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       a_flush, a_wr_en, a_rd_en, a_wr_rdy, a_rd_valid;
  logic [7:0] a_wr_data, a_rd_data;
  logic [2:0] a_count;
  logic       a_af, a_ae, a_ovf, a_unf;

  logic       b_flush, b_wr_en, b_rd_en, b_wr_rdy, b_rd_valid;
  logic [7:0] b_wr_data, b_rd_data;
  logic [2:0] b_count;
  logic       b_af, b_ae, b_ovf, b_unf;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(8), .DEPTH(4), .FWFT(1), .AFULL_THRESH(2), .AEMPTY_THRESH(2)) u_fwft (
    .CLK(clk), .RST_N(rst_n), .FLUSH(a_flush),
    .WR_RDY(a_wr_rdy), .WR_EN(a_wr_en), .WR_DATA(a_wr_data),
    .RD_VALID(a_rd_valid), .RD_EN(a_rd_en), .RD_DATA(a_rd_data),
    .COUNT(a_count), .ALMOST_FULL(a_af), .ALMOST_EMPTY(a_ae),
    .OVERFLOW(a_ovf), .UNDERFLOW(a_unf)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(4), .FWFT(0), .AFULL_THRESH(2), .AEMPTY_THRESH(2)) u_reg (
    .CLK(clk), .RST_N(rst_n), .FLUSH(b_flush),
    .WR_RDY(b_wr_rdy), .WR_EN(b_wr_en), .WR_DATA(b_wr_data),
    .RD_VALID(b_rd_valid), .RD_EN(b_rd_en), .RD_DATA(b_rd_data),
    .COUNT(b_count), .ALMOST_FULL(b_af), .ALMOST_EMPTY(b_ae),
    .OVERFLOW(b_ovf), .UNDERFLOW(b_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_flush = 0; a_wr_en = 0; a_rd_en = 0; a_wr_data = 0;
    b_flush = 0; b_wr_en = 0; b_rd_en = 0; b_wr_data = 0;
    #1;
    chk("rst_wr_rdy", a_wr_rdy, 1);
    chk("rst_rd_valid", a_rd_valid, 0);
    chk("rst_count", a_count, 0);
    chk("rst_ae", a_ae, 1);
    chk("rst_af", a_af, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_unf", a_unf, 0);
    chk("rst_b_rd_data", b_rd_data, 0);
    step();
    step();
    rst_n = 1'b1;

    // Fill the FWFT FIFO
    a_wr_en = 1; a_wr_data = 8'hA1;
    step();
    chk("w1_count", a_count, 1);
    chk("w1_rd_valid", a_rd_valid, 1);
    chk("w1_rd_data", a_rd_data, 8'hA1);
    chk("w1_af", a_af, 0);
    a_wr_data = 8'hA2;
    step();
    chk("w2_count", a_count, 2);
    chk("w2_af", a_af, 1);
    chk("w2_ae", a_ae, 1);
    chk("w2_rd_data", a_rd_data, 8'hA1);
    a_wr_data = 8'hA3;
    step();
    chk("w3_count", a_count, 3);
    chk("w3_ae", a_ae, 0);
    a_wr_data = 8'hA4;
    step();
    chk("w4_count", a_count, 4);
    chk("w4_wr_rdy", a_wr_rdy, 0);
    chk("w4_ovf", a_ovf, 0);

    // Full with simultaneous write and read
    a_wr_data = 8'hEE; a_rd_en = 1;
    step();
    chk("full_rw_count", a_count, 3);
    chk("full_rw_ovf", a_ovf, 1);
    chk("full_rw_rd_data", a_rd_data, 8'hA2);
    chk("full_rw_wr_rdy", a_wr_rdy, 1);

    // Drain; the refused 0xEE must not appear
    a_wr_en = 0;
    step();
    chk("drain1_data", a_rd_data, 8'hA3);
    chk("drain1_count", a_count, 2);
    step();
    chk("drain2_data", a_rd_data, 8'hA4);
    chk("drain2_count", a_count, 1);
    step();
    chk("drain3_count", a_count, 0);
    chk("drain3_rd_valid", a_rd_valid, 0);
    chk("drain3_unf", a_unf, 0);
    chk("drain3_ovf_sticky", a_ovf, 1);

    // Read while empty
    step();
    chk("empty_rd_unf", a_unf, 1);
    chk("empty_rd_count", a_count, 0);
    a_rd_en = 0; a_flush = 1;
    step();
    chk("flush_unf", a_unf, 0);
    chk("flush_ovf", a_ovf, 0);
    a_flush = 0;

    // Flush outranks same-cycle write and read
    a_wr_en = 1; a_wr_data = 8'h11;
    step();
    chk("pre_flush_count", a_count, 1);
    a_flush = 1; a_rd_en = 1; a_wr_data = 8'h12;
    step();
    chk("flush_prio_count", a_count, 0);
    chk("flush_prio_ovf", a_ovf, 0);
    chk("flush_prio_unf", a_unf, 0);
    chk("flush_prio_rd_valid", a_rd_valid, 0);
    a_flush = 0; a_rd_en = 0;

    // Streaming across many wraps with occupancy held at 2
    a_wr_data = 8'h00;
    step();
    a_wr_data = 8'h01;
    step();
    chk("stream_prefill_count", a_count, 2);
    a_rd_en = 1;
    for (int i = 2; i < 16; i++) begin
      a_wr_data = 8'(i);
      chk($sformatf("stream_data_%0d", i - 2), a_rd_data, 32'(i - 2));
      step();
      chk($sformatf("stream_count_%0d", i), a_count, 2);
    end
    a_wr_en = 0;
    chk("stream_data_14", a_rd_data, 8'h0E);
    step();
    chk("stream_data_15", a_rd_data, 8'h0F);
    step();
    chk("stream_end_count", a_count, 0);
    a_rd_en = 0;

    // Registered-read instance
    b_wr_en = 1; b_wr_data = 8'h55;
    step();
    b_wr_en = 0;
    chk("reg_w_rd_valid", b_rd_valid, 1);
    chk("reg_w_count", b_count, 1);
    chk("reg_w_rd_data_hold", b_rd_data, 0);
    b_rd_en = 1;
    step();
    b_rd_en = 0;
    chk("reg_r_rd_data", b_rd_data, 8'h55);
    chk("reg_r_rd_valid", b_rd_valid, 0);
    chk("reg_r_count", b_count, 0);
    step();
    chk("reg_hold_rd_data", b_rd_data, 8'h55);
    b_flush = 1;
    step();
    b_flush = 0;
    chk("reg_flush_keeps_data", b_rd_data, 8'h55);

    // Asynchronous reset mid-burst
    a_wr_en = 1;
    a_wr_data = 8'h31; step();
    a_wr_data = 8'h32; step();
    a_wr_data = 8'h33; step();
    a_wr_en = 0;
    chk("burst_count", a_count, 3);
    rst_n = 1'b0;
    #1;
    chk("arst_wr_rdy", a_wr_rdy, 1);
    chk("arst_rd_valid", a_rd_valid, 0);
    chk("arst_count", a_count, 0);
    chk("arst_b_rd_data", b_rd_data, 0);
    step();
    rst_n = 1'b1;
    a_wr_en = 1; a_wr_data = 8'h77;
    step();
    a_wr_en = 0;
    chk("post_rst_rd_data", a_rd_data, 8'h77);
    chk("post_rst_count", a_count, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
